// File: rtl/alu_functional_unit.sv
// Integer ALU functional unit: registered execute stage feeding a small
// result FIFO that arbitrates for the common data bus.
module alu_functional_unit #(
    parameter int RESULT_DEPTH = 4,
    parameter int ROB_IX_W     = 3
) (
    input  logic                clk_in,
    input  logic                rst_in,
    input  logic                valid_in,
    input  logic [31:0]         rval1_in,
    input  logic [31:0]         rval2_in,
    input  logic [3:0]          opcode_in,
    input  logic [ROB_IX_W-1:0] rob_ix_in,
    input  logic                flush_in,
    input  logic                cdb_grant_in,
    output logic                fu_busy_out,
    output logic                cdb_req_out,
    output logic [ROB_IX_W-1:0] cdb_rob_ix_out,
    output logic [31:0]         cdb_value_out,
    output logic                cdb_valid_out,
    output logic                overflow_out
);

    localparam int PW = (RESULT_DEPTH > 1) ? $clog2(RESULT_DEPTH) : 1;
    localparam int CW = PW + 2;

    logic                r_ex_valid;
    logic [31:0]         r_ex_a;
    logic [31:0]         r_ex_b;
    logic [3:0]          r_ex_op;
    logic [ROB_IX_W-1:0] r_ex_tag;
    logic [CW-1:0]       r_cnt;
    logic [PW-1:0]       r_rd;
    logic [PW-1:0]       r_wr;
    logic                r_overflow;
    logic [31:0]         r_val_mem [RESULT_DEPTH];
    logic [ROB_IX_W-1:0] r_tag_mem [RESULT_DEPTH];

    logic [CW-1:0]       w_occ;
    logic                w_room;
    logic                w_accept;
    logic                w_push;
    logic                w_pop;
    logic                w_nonempty;
    logic [4:0]          w_shamt;
    logic [31:0]         w_result;

    // Same-cycle grants are not credited, so busy is conservative.
    assign w_occ       = r_cnt + CW'(r_ex_valid);
    assign w_room      = w_occ < CW'(RESULT_DEPTH);
    assign fu_busy_out = (w_occ + CW'(valid_in)) >= CW'(RESULT_DEPTH);
    assign w_accept    = valid_in & ~flush_in & w_room;
    assign w_push      = r_ex_valid & ~flush_in;
    assign w_nonempty  = r_cnt != '0;
    assign w_pop       = w_nonempty & cdb_grant_in;

    assign cdb_req_out    = w_nonempty;
    assign cdb_valid_out  = w_pop;
    assign cdb_rob_ix_out = w_nonempty ? r_tag_mem[r_rd] : '0;
    assign cdb_value_out  = w_nonempty ? r_val_mem[r_rd] : '0;
    assign overflow_out   = r_overflow;

    assign w_shamt = r_ex_b[4:0];

    always_comb begin
        w_result = '0;
        unique case (r_ex_op)
            4'd0:    w_result = r_ex_a + r_ex_b;
            4'd1:    w_result = r_ex_a - r_ex_b;
            4'd2:    w_result = r_ex_a & r_ex_b;
            4'd3:    w_result = r_ex_a | r_ex_b;
            4'd4:    w_result = r_ex_a ^ r_ex_b;
            4'd5:    w_result = {31'd0, $signed(r_ex_a) < $signed(r_ex_b)};
            4'd6:    w_result = {31'd0, r_ex_a < r_ex_b};
            4'd7:    w_result = r_ex_a << w_shamt;
            4'd8:    w_result = r_ex_a >> w_shamt;
            4'd9:    w_result = 32'($signed(r_ex_a) >>> w_shamt);
            default: w_result = '0;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            r_ex_valid <= 1'b0;
            r_cnt      <= '0;
            r_rd       <= '0;
            r_wr       <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_ex_valid <= w_accept;
            if (valid_in && !flush_in && !w_room) begin
                r_overflow <= 1'b1;
            end
            if (flush_in) begin
                r_cnt <= '0;
                r_rd  <= '0;
                r_wr  <= '0;
            end else begin
                if (w_push) r_wr <= r_wr + 1'b1;
                if (w_pop)  r_rd <= r_rd + 1'b1;
                if (w_push && !w_pop)      r_cnt <= r_cnt + 1'b1;
                else if (!w_push && w_pop) r_cnt <= r_cnt - 1'b1;
            end
        end
    end

    // Datapath storage carries no reset; validity lives in the counters.
    always_ff @(posedge clk_in) begin
        if (w_accept) begin
            r_ex_a   <= rval1_in;
            r_ex_b   <= rval2_in;
            r_ex_op  <= opcode_in;
            r_ex_tag <= rob_ix_in;
        end
        if (rst_in && w_push) begin
            r_val_mem[r_wr] <= w_result;
            r_tag_mem[r_wr] <= r_ex_tag;
        end
    end

endmodule

// File: doc/alu_functional_unit.md
Name: alu_functional_unit

Overview:
- Integer ALU functional unit sitting directly downstream of the reservation station.
- Accepts one dispatched operation per cycle: operands, opcode and ROB tag.
- Computes the result in a registered execute stage and queues it in a small result FIFO.
- Arbitrates for the common data bus (CDB) with a req/grant handshake and drives the CDB tag/value when granted.

Parameters:
- RESULT_DEPTH, 4, result FIFO entries (power of 2, ≥2).
- ROB_IX_W, 3, ROB tag width (ROB has 8 entries).

Ports:
- clk_in  input  1  clock.
- rst_in  input  1  reset, synchronous, active-low.
- valid_in  input  1  dispatched op valid this cycle (rs_output_valid).
- rval1_in  input  32  operand 1, signed.
- rval2_in  input  32  operand 2, signed.
- opcode_in  input  4  AluFunc.
- rob_ix_in  input  ROB_IX_W  destination ROB tag.
- flush_in  input  1  squash all in-flight work.
- cdb_grant_in  input  1  CDB arbiter grants this unit this cycle.
- fu_busy_out  output  1  unit cannot take a new op (to RS fu_busy).
- cdb_req_out  output  1  result pending, requesting CDB.
- cdb_rob_ix_out  output  ROB_IX_W  tag of head result.
- cdb_value_out  output  32  value of head result.
- cdb_valid_out  output  1  = cdb_req_out & cdb_grant_in; broadcast valid.
- overflow_out  output  1  sticky: op arrived while unable to store.

Behaviour:
- Opcode encoding and results (r1 = rval1, r2 = rval2):
  - 0 Add: r1+r2, mod 2^32.
  - 1 Sub: r1-r2, mod 2^32.
  - 2 And, 3 Or, 4 Xor: bitwise.
  - 5 Slt: signed r1<r2 → 1, else 0.
  - 6 Sltu: unsigned compare, same result encoding.
  - 7 Sll, 8 Srl, 9 Sra: shift amount r2[4:0].
  - 10–15: result 0, still broadcast.
- Execute register (ex_valid, ex operands, ex opcode, ex tag):
  - Loaded at an edge where valid_in=1 and the unit accepts.
  - ex_valid cleared otherwise.
- Result write: at the edge after ex_valid=1, the computed result and tag are pushed into the result FIFO.
- Latency: op accepted at edge k reaches the FIFO at edge k+1. If the FIFO was empty, cdb_req_out=1 with correct tag/value during the cycle after edge k+1.
- CDB handshake:
  - cdb_req_out = FIFO non-empty.
  - Head data stable while cdb_req_out=1 and not granted.
  - Head popped at an edge where cdb_req_out & cdb_grant_in.
  - Grant while empty: ignored, cdb_valid_out=0.
- Push and pop in the same edge: count unchanged; the head advances correctly, including when count=1 (the new entry becomes head).
- fu_busy_out (combinational) = (count + ex_valid + valid_in) ≥ RESULT_DEPTH.
  - Grants in the same cycle are not credited (conservative).
  - This covers the RS one-cycle send lag.
- Accept rule: valid_in is accepted iff count + ex_valid < RESULT_DEPTH.
  - Otherwise the op is dropped and overflow_out is set to 1 until reset.
- Pointer wrap: FIFO read/write pointers wrap modulo RESULT_DEPTH; full/empty are tracked by count.
- flush_in=1 at an edge:
  - Clears ex_valid and FIFO count/pointers, and ignores valid_in that cycle.
  - cdb_req_out=0 the next cycle.
  - overflow_out is unaffected.
- flush_in together with cdb_grant_in: the grant still produces cdb_valid_out=1 that cycle, because the broadcast is already on the bus.
- Reset (rst_in=0 at an edge):
  - ex_valid=0, count=0, pointers=0, overflow_out=0.
  - Resulting outputs: cdb_req_out=0, cdb_valid_out=0, fu_busy_out=valid_in-driven only, cdb_rob_ix_out=0, cdb_value_out=0.
  - Reset mid-operation discards all work with no broadcast.

Test Plan:
1. Reset, then valid_in with Add 5+(-7), tag 3, cdb_grant_in held 1:
   - cdb_req_out rises 2 edges after valid_in; cdb_value_out=-2, cdb_rob_ix_out=3.
   - cdb_valid_out=1 for exactly one cycle.
2. Opcode sweep with r1=0x80000000, r2=1:
   - Slt→1, Sltu→0, Sra(r2=4)→0xF8000000, Srl(4)→0x08000000, Sll(1)→0.
   - Opcode 12→0.
3. Grant held 0, one op issued per cycle:
   - fu_busy_out asserts once count+ex_valid+valid_in=4; no op is lost; overflow_out stays 0.
   - Then grant held 1: results drain in issue order with tags 0,1,2,3.
4. Ignore fu_busy_out and keep pushing while full:
   - overflow_out=1 and sticky; FIFO contents are unchanged.
5. Simultaneous push/pop with count=1 and grant each cycle:
   - Streaming 6 ops back-to-back gives one broadcast per cycle, in order, with count never exceeding 1.
6. flush_in with 3 queued results:
   - Next cycle cdb_req_out=0; a later op broadcasts normally.
   - Asserting rst_in=0 mid-stream clears all outputs to their reset values.
